// File: rtl/dpwm_multicell_updown.sv
// Phase-shifted multi-cell DPWM for one FCML leg. A single master up/down
// carrier is shared by all cells; each cell sees it rotated by a constant
// offset, compares against a valley-updated duty and inserts dead time.
module dpwm_multicell_updown #(
    parameter int N_CELLS  = 5,
    parameter int CNT_W    = 11,
    parameter int PERIOD   = 1000,
    parameter int DT_W     = 6,
    parameter int DEADTIME = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_en,
    input  logic [CNT_W-1:0]   duty_in,
    input  logic               duty_ld,
    output logic [N_CELLS-1:0] dpwm_s,
    output logic [N_CELLS-1:0] dpwm_sb,
    output logic               sync_out
);
    // one extra bit so 2*PERIOD-1 always fits
    localparam int               M_W     = CNT_W + 1;
    localparam logic [M_W-1:0]   PER_M   = M_W'(PERIOD);
    localparam logic [M_W-1:0]   TWO_P_M = M_W'(2 * PERIOD);
    localparam logic [M_W-1:0]   M_LAST  = M_W'(2 * PERIOD - 1);
    localparam logic [CNT_W-1:0] PER_C   = CNT_W'(PERIOD);
    localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEADTIME);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    typedef enum logic [1:0] {ST_NONE, ST_ON_S, ST_ON_SB, ST_DEAD} dt_state_e;

    logic [M_W-1:0]   m_q, m_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             sync_q, sync_d;

    // master carrier position, valley sync and saturating shadow capture
    always_comb begin
        m_d      = m_q;
        sync_d   = pwm_en && (m_q == '0);
        shadow_d = shadow_q;
        if (!pwm_en || m_q == M_LAST) m_d = '0;
        else                          m_d = m_q + M_W'(1);
        if (duty_ld) shadow_d = (duty_in > PER_C) ? PER_C : duty_in;
    end

    // shared state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q      <= '0;
            shadow_q <= '0;
            sync_q   <= 1'b0;
        end else begin
            m_q      <= m_d;
            shadow_q <= shadow_d;
            sync_q   <= sync_d;
        end
    end

    assign sync_out = sync_q;

    for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
        localparam int             OFF   = (k * 2 * PERIOD) / N_CELLS;
        localparam logic [M_W-1:0] OFF_M = M_W'(OFF);
        // m value at which this cell's position wraps back to its valley
        localparam logic [M_W-1:0] WRAP  = M_W'(2 * PERIOD - OFF);

        logic [M_W-1:0]   pos, tri_w;
        logic [CNT_W-1:0] act_q, act_d;
        logic             raw_q, raw_d;
        logic             pend_q, pend_d;
        logic [DT_W-1:0]  cnt_q, cnt_d;
        dt_state_e        st_q, st_d;
        logic             enter, commit;

        // rotated carrier, valley-gated duty copy and registered compare
        always_comb begin
            pos   = (m_q >= WRAP) ? (m_q - WRAP) : (m_q + OFF_M);
            tri_w = (pos < PER_M) ? pos : (TWO_P_M - pos);
            act_d = act_q;
            if (!pwm_en || pos == '0) act_d = shadow_q;
            raw_d = pwm_en && ({1'b0, act_q} > tri_w);
        end

        // dead-time FSM: any disagreement with the committed level blanks
        // both gates; the new level commits after it stays stable
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            pend_d = pend_q;
            enter  = 1'b0;
            commit = 1'b0;
            case (st_q)
                ST_NONE:  enter = 1'b1;
                ST_ON_S:  enter = !raw_q;
                ST_ON_SB: enter = raw_q;
                ST_DEAD: begin
                    if (raw_q != pend_q)      enter  = 1'b1;
                    else if (cnt_q <= DT_ONE) commit = 1'b1;
                    else                      cnt_d  = cnt_q - DT_ONE;
                end
            endcase
            // zero dead time swaps straight to the new level
            if (enter && (DEADTIME == 0)) commit = 1'b1;
            if (commit) begin
                st_d  = raw_q ? ST_ON_S : ST_ON_SB;
                cnt_d = '0;
            end else if (enter) begin
                st_d   = ST_DEAD;
                cnt_d  = DT_LOAD;
                pend_d = raw_q;
            end
            if (!pwm_en) begin
                st_d   = ST_NONE;
                cnt_d  = '0;
                pend_d = 1'b0;
            end
        end

        // per-cell registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                act_q  <= '0;
                raw_q  <= 1'b0;
                pend_q <= 1'b0;
                cnt_q  <= '0;
                st_q   <= ST_NONE;
            end else begin
                act_q  <= act_d;
                raw_q  <= raw_d;
                pend_q <= pend_d;
                cnt_q  <= cnt_d;
                st_q   <= st_d;
            end
        end

        assign dpwm_s[k]  = (st_q == ST_ON_S);
        assign dpwm_sb[k] = (st_q == ST_ON_SB);
    end

endmodule

// File: tb/tb_dpwm_multicell_updown.sv
// Randomised bench for dpwm_multicell_updown against a cycle model built from
// the carrier/duty rules and a "stable for DEADTIME+1 samples" gate rule.
module tb_dpwm_multicell_updown;
    localparam int N   = 5;
    localparam int CW  = 12;
    localparam int P   = 100;
    localparam int DTW = 6;
    localparam int DT  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_en;
    logic          duty_ld;
    logic [CW-1:0] duty_in;
    logic [N-1:0]  dpwm_s;
    logic [N-1:0]  dpwm_sb;
    logic          sync_out;

    dpwm_multicell_updown #(
        .N_CELLS(N), .CNT_W(CW), .PERIOD(P), .DT_W(DTW), .DEADTIME(DT)
    ) dut (
        .clk(clk), .rst(rst), .pwm_en(pwm_en), .duty_in(duty_in),
        .duty_ld(duty_ld), .dpwm_s(dpwm_s), .dpwm_sb(dpwm_sb),
        .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int md, shd;
    int act [N];
    bit rawm[N];
    bit lvl [N];   // level raw has held for the last run[k] enabled samples
    int run [N];
    bit synm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tri_at(input int k, input int mm);
        int pos;
        pos = (mm + (k * 2 * P) / N) % (2 * P);
        return (pos < P) ? pos : 2 * P - pos;
    endfunction

    function automatic logic [N-1:0] exp_gate(input bit lv);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (run[k] >= DT + 1) && (lvl[k] == lv);
        return r;
    endfunction

    task automatic model_reset();
        md = 0; shd = 0; synm = 1'b0;
        for (int k = 0; k < N; k++) begin
            act[k] = 0; rawm[k] = 1'b0; lvl[k] = 1'b0; run[k] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit ld, input int d);
        int pos;
        synm = en && (md == 0);
        for (int k = 0; k < N; k++) begin
            if (!en) run[k] = 0;
            else if (run[k] > 0 && rawm[k] == lvl[k]) begin
                if (run[k] < 1000) run[k]++;
            end else begin
                lvl[k] = rawm[k];
                run[k] = 1;
            end
            pos     = (md + (k * 2 * P) / N) % (2 * P);
            rawm[k] = en && (act[k] > tri_at(k, md));
            if (!en || pos == 0) act[k] = shd;
        end
        if (ld) shd = (d > P) ? P : d;
        md = en ? (md + 1) % (2 * P) : 0;
    endtask

    // drive at negedge, advance model at posedge, compare at next negedge
    task automatic step(input bit en, input bit ld, input int d);
        pwm_en  = en;
        duty_ld = ld;
        duty_in = CW'(d);
        @(posedge clk);
        model_edge(en, ld, d);
        @(negedge clk);
        chk("s", 32'(dpwm_s), 32'(exp_gate(1'b1)));
        chk("sb", 32'(dpwm_sb), 32'(exp_gate(1'b0)));
        chk("sync", 32'(sync_out), 32'(synm));
        chk("overlap", 32'(dpwm_s & dpwm_sb), 32'd0);
    endtask

    task automatic rand_run(input int cycles);
        bit en;
        bit ld;
        int off_cnt;
        int d;
        en = 1'b1;
        off_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (en && $urandom_range(0, 399) == 0) begin
                en = 1'b0;
                off_cnt = $urandom_range(1, 20);
            end else if (!en) begin
                off_cnt--;
                if (off_cnt <= 0) en = 1'b1;
            end
            ld = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = P;
                2:       d = P - 1;
                3:       d = 4095;
                4:       d = $urandom_range(P + 1, 4095);
                default: d = $urandom_range(0, P);
            endcase
            step(en, ld, d);
        end
    endtask

    // count gate-high cycles per cell over one carrier period
    task automatic count_period(input string tag, input int exp_s, input int exp_sb);
        int hs[N];
        int hb[N];
        int ns;
        ns = 0;
        for (int k = 0; k < N; k++) begin hs[k] = 0; hb[k] = 0; end
        for (int i = 0; i < 2 * P; i++) begin
            step(1'b1, 1'b0, 0);
            for (int k = 0; k < N; k++) begin
                hs[k] += int'(dpwm_s[k]);
                hb[k] += int'(dpwm_sb[k]);
            end
            ns += int'(sync_out);
        end
        for (int k = 0; k < N; k++) begin
            chk({tag, "_s_high"}, 32'(hs[k]), 32'(exp_s));
            chk({tag, "_sb_high"}, 32'(hb[k]), 32'(exp_sb));
        end
        chk({tag, "_sync_cnt"}, 32'(ns), 32'd1);
    endtask

    initial begin
        int guard;
        bit in_dead;
        rst = 1'b1; pwm_en = 1'b0; duty_ld = 1'b0; duty_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_s", 32'(dpwm_s), 32'd0);
        chk("rst_sb", 32'(dpwm_sb), 32'd0);
        chk("rst_sync", 32'(sync_out), 32'd0);
        rst = 1'b0;

        // duty 0 from reset: bottom gates appear after 1+DT enabled edges
        for (int i = 0; i < DT; i++) step(1'b1, 1'b0, 0);
        chk("en_sb_early", 32'(dpwm_sb), 32'd0);
        step(1'b1, 1'b0, 0);
        chk("en_sb_first", 32'(dpwm_sb), 32'(5'b11111));

        // duty 50: raw high 99 of 200 (tri 0..49), s loses DT at its rise;
        // raw low 101, sb loses DT likewise
        step(1'b1, 1'b1, 50);
        for (int i = 0; i < 599; i++) step(1'b1, 1'b0, 0);
        count_period("d50", 99 - DT, 101 - DT);

        // disable mid-run: everything off on the next clock
        step(1'b0, 1'b0, 0);
        chk("dis_s", 32'(dpwm_s), 32'd0);
        chk("dis_sb", 32'(dpwm_sb), 32'd0);

        rand_run(3000);

        // saturation: 4095 clamps to PERIOD; raw drops only at the peak,
        // which blanks s for 1+DT cycles and never lets sb through
        step(1'b1, 1'b1, 4095);
        for (int i = 0; i < 599; i++) step(1'b1, 1'b0, 0);
        count_period("sat", 2 * P - 1 - DT, 0);

        // change duty, then hit async reset while some cell is in dead time
        step(1'b1, 1'b1, 30);
        guard = 0;
        in_dead = 1'b0;
        while (!in_dead && guard < 400) begin
            step(1'b1, 1'b0, 0);
            guard++;
            for (int k = 0; k < N; k++) if (run[k] > 0 && run[k] <= DT) in_dead = 1'b1;
        end
        chk("find_dead", 32'(in_dead), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_s", 32'(dpwm_s), 32'd0);
        chk("arst_sb", 32'(dpwm_sb), 32'd0);
        chk("arst_sync", 32'(sync_out), 32'd0);
        model_reset();
        @(negedge clk);
        chk("arst_hold_s", 32'(dpwm_s), 32'd0);
        rst = 1'b0;

        rand_run(2000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
